// File: rtl/fitness_pkg.sv
// Shared definitions for the fitness blocks: the step_counter debounce FSM
// encoding, the system clock rate and the step-count width. The
// steps-per-minute block uses the same CLK_HZ and STEP_W.
package fitness_pkg;

  localparam int CLK_HZ = 100_000_000;
  localparam int STEP_W = 16;

  // Press/release debounce FSM states.
  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } deb_state_e;

  // Width of a counter that counts 0..n-1 (always at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/step_debounce.sv
// Synchronizes the raw step sensor level and runs the press/release debounce
// FSM. press_accepted pulses for one cycle: the cycle whose closing edge moves
// the FSM from DEB_PRESS to PRESSED.
module step_debounce
  import fitness_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic step_in,
  output logic press_accepted
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);

  logic          s_meta;
  logic          s_in;
  deb_state_e    state;
  deb_state_e    state_next;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_next;

  // Two-flop synchronizer for the asynchronous sensor level.
  // NOTE: registers use non-blocking assignments so both flops sample the
  // pre-edge values; blocking would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_meta <= 1'b0;
      s_in   <= 1'b0;
    end else begin
      s_meta <= step_in;
      s_in   <= s_meta;
    end
  end

  // FSM state and debounce counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: a level must hold for DEBOUNCE_CYCLES consecutive
  // cycles in a DEB_* state before the transition is accepted.
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    press_accepted = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_in) begin
          state_next = DEB_PRESS;
          cnt_next   = '0;
        end
      end
      DEB_PRESS: begin
        if (!s_in) begin
          state_next = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_next     = PRESSED;
          press_accepted = 1'b1;
        end else begin
          cnt_next = cnt + DEB_ONE;
        end
      end
      PRESSED: begin
        if (!s_in) begin
          state_next = DEB_RELEASE;
          cnt_next   = '0;
        end
      end
      DEB_RELEASE: begin
        if (s_in) begin
          state_next = PRESSED;
        end else if (cnt == DEB_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + DEB_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/step_counter.sv
// Step counter: debounced presses, a minimum-interval holdoff between counted
// steps, a 16-bit step count with a sticky overflow flag and a synchronous clear.
// Build option STEP_COUNT_SAT_EN: when defined the count saturates at 0xFFFF;
// when undefined it wraps to 0x0000. overflow is set in both cases.
module step_counter
  import fitness_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int MIN_INTERVAL_CYCLES = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_in,
  input  logic              clr,
  output logic [STEP_W-1:0] step_count,
  output logic              step_tick,
  output logic              overflow
);

  localparam int HW = cnt_width(MIN_INTERVAL_CYCLES);
  localparam logic [HW-1:0]     HOLD_LOAD = HW'(MIN_INTERVAL_CYCLES - 1);
  localparam logic [HW-1:0]     HOLD_ONE  = HW'(1);
  localparam logic [STEP_W-1:0] COUNT_MAX = '1;
  localparam logic [STEP_W-1:0] COUNT_ONE = STEP_W'(1);

  logic          press_accepted;
  logic [HW-1:0] holdoff;

  step_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk           (clk),
    .rst           (rst),
    .step_in       (step_in),
    .press_accepted(press_accepted)
  );

  // A press counts only once the holdoff from the previous counted step has
  // expired; the tick is high in the same cycle as press_accepted.
  assign step_tick = press_accepted && (holdoff == '0);

  // Holdoff timer: reloaded by a counted step, runs down to zero. clr leaves
  // it alone so clearing the display cannot shorten the interval.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      holdoff <= '0;
    end else if (step_tick) begin
      holdoff <= HOLD_LOAD;
    end else if (holdoff != '0) begin
      holdoff <= holdoff - HOLD_ONE;
    end
  end

  // Step count and sticky overflow; clr wins over a simultaneous step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_count <= '0;
      overflow   <= 1'b0;
    end else if (clr) begin
      step_count <= '0;
      overflow   <= 1'b0;
    end else if (step_tick) begin
`ifdef STEP_COUNT_SAT_EN
      if (step_count != COUNT_MAX) begin
        step_count <= step_count + COUNT_ONE;
        if (step_count == COUNT_MAX - COUNT_ONE) begin
          overflow <= 1'b1;
        end
      end
`else
      step_count <= step_count + COUNT_ONE;
      if (step_count == COUNT_MAX) begin
        overflow <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_step_counter.sv
// Self-checking bench for step_counter with DEBOUNCE_CYCLES=4 and
// MIN_INTERVAL_CYCLES=20. A reference model works on the sampled input level
// as run lengths (how long the synchronized level has differed from the
// debounced level) and on edge indices for the step interval.
module tb_step_counter;

  localparam int DEB     = 4;
  localparam int MIN_GAP = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        step_in;
  logic        clr;
  logic [15:0] step_count;
  logic        step_tick;
  logic        overflow;

  always #5 clk = ~clk;

  step_counter #(
    .DEBOUNCE_CYCLES    (DEB),
    .MIN_INTERVAL_CYCLES(MIN_GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .step_in   (step_in),
    .clr       (clr),
    .step_count(step_count),
    .step_tick (step_tick),
    .overflow  (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", tag, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [1:0] m_sync;    // [0] first sample, [1] level seen by the debouncer
  bit       m_level;   // debounced level
  int       m_run;     // consecutive edges the sampled level differed from m_level
  longint   m_edge;    // clock edges since reset
  longint   m_last;    // edge index of the last counted step
  bit       m_any;     // a step has been counted since reset
  int       m_count;
  bit       m_ovf;

  task automatic model_reset();
    m_sync  = '0;
    m_level = 1'b0;
    m_run   = 0;
    m_edge  = 0;
    m_last  = 0;
    m_any   = 1'b0;
    m_count = 0;
    m_ovf   = 1'b0;
  endtask

  // A press is accepted on the edge where the high level has been seen for
  // DEB+1 consecutive edges (one to leave IDLE, DEB to debounce); it counts if
  // at least MIN_GAP edges have passed since the previous counted step.
  function automatic bit m_tick();
    bit gap_ok;
    gap_ok = !m_any || ((m_edge + 1 - m_last) >= MIN_GAP);
    return !m_level && m_sync[1] && (m_run == DEB) && gap_ok;
  endfunction

  task automatic model_edge(input bit x, input bit c);
    bit s;
    bit counted;
    s       = m_sync[1];
    counted = m_tick();
    m_edge++;
    if (s != m_level) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_level = s;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    if (counted) begin
      m_last = m_edge;
      m_any  = 1'b1;
    end
    if (c) begin
      m_count = 0;
      m_ovf   = 1'b0;
    end else if (counted) begin
`ifdef STEP_COUNT_SAT_EN
      if (m_count < 16'hFFFF) m_count++;
      if (m_count == 16'hFFFF) m_ovf = 1'b1;
`else
      if (m_count == 16'hFFFF) begin
        m_count = 0;
        m_ovf   = 1'b1;
      end else begin
        m_count++;
      end
`endif
    end
    m_sync = {m_sync[0], x};
  endtask

  // ---------------- stimulus helpers ----------------
  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle(input bit x, input bit c, output bit t);
    step_in = x;
    clr     = c;
    #1;
    check("step_tick", {31'b0, step_tick}, {31'b0, m_tick()});
    t = step_tick;
    @(posedge clk);
    model_edge(x, c);
    #1;
    check("step_count", {16'b0, step_count}, 32'(m_count));
    check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    @(negedge clk);
  endtask

  task automatic press(input int high, input int low, output int ticks);
    bit t;
    ticks = 0;
    for (int i = 0; i < high + low; i++) begin
      cycle(i < high, 1'b0, t);
      ticks += int'(t);
    end
  endtask

  // Asynchronous reset pulse lasting n extra cycles, released on a falling edge.
  task automatic do_reset(input int n);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_count", {16'b0, step_count}, 32'd0);
    check("rst_tick", {31'b0, step_tick}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      check("rst_hold_count", {16'b0, step_count}, 32'd0);
      check("rst_hold_tick", {31'b0, step_tick}, 32'd0);
      check("rst_hold_ovf", {31'b0, overflow}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ticks;
    int  lat;
    bit  t;
    bit  c;
    bit  seen;
    bit  lvl;
    int  len;

    rst     = 1'b1;
    step_in = 1'b0;
    clr     = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // Clean press: exactly one tick, count 0 -> 1.
    press(10, 10, ticks);
    check("clean_ticks", 32'(ticks), 32'd1);
    check("clean_count", {16'b0, step_count}, 32'd1);

    // Two-cycle glitch is rejected.
    do_reset(1);
    press(2, 10, ticks);
    check("glitch_ticks", 32'(ticks), 32'd0);
    check("glitch_count", {16'b0, step_count}, 32'd0);

    // Second press 12 cycles after the first tick is ignored; a third one 25
    // cycles after the first counted tick is counted.
    do_reset(1);
    press(6, 6, ticks);
    check("gap_first", 32'(ticks), 32'd1);
    press(6, 7, ticks);
    check("gap12_ignored", 32'(ticks), 32'd0);
    check("gap12_count", {16'b0, step_count}, 32'd1);
    press(6, 10, ticks);
    check("gap25_counted", 32'(ticks), 32'd1);
    check("gap25_count", {16'b0, step_count}, 32'd2);

    // clr in the tick cycle with count 5.
    do_reset(1);
    for (int i = 0; i < 5; i++) press(6, 20, ticks);
    check("five_count", {16'b0, step_count}, 32'd5);
    seen = 1'b0;
    for (int i = 0; i < 26; i++) begin
      c = m_tick();
      cycle(i < 6, c, t);
      if (c && t) seen = 1'b1;
    end
    check("clr_tick_seen", {31'b0, seen}, 32'd1);
    check("clr_count", {16'b0, step_count}, 32'd0);
    check("clr_ovf", {31'b0, overflow}, 32'd0);

    // Preload near the top of the range, then step across it.
    force dut.step_count = 16'hFFFD;
    #1;
    release dut.step_count;
    m_count = 16'hFFFD;
    press(6, 20, ticks);
    check("pre_fffe_count", {16'b0, step_count}, 32'hFFFE);
    check("pre_fffe_ovf", {31'b0, overflow}, 32'd0);
    press(6, 20, ticks);
    press(6, 20, ticks);
`ifdef STEP_COUNT_SAT_EN
    check("top_count", {16'b0, step_count}, 32'hFFFF);
`else
    check("top_count", {16'b0, step_count}, 32'h0000);
`endif
    check("top_ovf", {31'b0, overflow}, 32'd1);
    cycle(1'b0, 1'b1, t);
    check("top_clr_count", {16'b0, step_count}, 32'd0);
    check("top_clr_ovf", {31'b0, overflow}, 32'd0);

    // Reset in the middle of DEB_PRESS with the button held throughout:
    // the tick follows two synchronizer edges plus the full debounce.
    do_reset(1);
    press(4, 0, ticks);
    do_reset(3);
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      cycle(1'b1, 1'b0, t);
      if (t) lat = i - 1;
    end
    check("rst_mid_latency", 32'(lat), 32'(DEB + 2));
    press(0, 12, ticks);

    // Randomized levels, clears and occasional resets against the model.
    for (int seg = 0; seg < 250; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      if ($urandom_range(0, 39) == 0) do_reset(2);
      for (int j = 0; j < len; j++) begin
        cycle(lvl, $urandom_range(0, 19) == 0, t);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
